scs8hd_a2111oi_pipe: RTL and testbench



---
 rtl/scs8hd_a2111oi_pipe.sv | 116 +++++++++++
 tb/tb_scs8hd_a2111oi_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_a2111oi_pipe.sv
// Lane-parallel AND-OR(-INVERT) decode feeding a STAGES-deep elastic pipeline.
// Optional power-good checking is built when SCS8HD_PG_CHECK_EN is defined.
module scs8hd_a2111oi_pipe #(
  parameter  int WIDTH  = 4,
  parameter  int N_A    = 2,
  parameter  int STAGES = 2,
  parameter  int MODE   = 0,
  localparam int OW     = $clog2(STAGES + 1)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH*N_A-1:0] A,
  input  logic [WIDTH-1:0]     B1,
  input  logic [WIDTH-1:0]     C1,
  input  logic [WIDTH-1:0]     D1,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [WIDTH-1:0]     Y,
  output logic [OW-1:0]        OCC
`ifdef SCS8HD_PG_CHECK_EN
  ,
  input  logic                 vpwr,
  input  logic                 vgnd
`endif
);

  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be >= 1");
  end
  if (N_A < 1) begin : g_bad_na
    $error("N_A must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("STAGES must be >= 1");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("MODE must be 0 or 1");
  end

  logic [WIDTH-1:0]  f;
  logic [WIDTH-1:0]  d_in;
  logic [WIDTH-1:0]  d_ld;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic              ld_x;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign f[i] = (&A[i*N_A +: N_A]) | B1[i] | C1[i] | D1[i];
  end

  assign d_in = (MODE == 0) ? ~f : f;

  // rdy_k = !valid_k | rdy_(k+1), unrolled so no comb chain through rdy
  for (genvar k = 0; k < STAGES; k++) begin : g_rdy
    assign rdy[k] = OUT_READY | ~(&valid_q[STAGES-1:k]);
  end

  assign IN_READY = rdy[0];
  assign OCC      = OW'($countones(valid_q));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      if (rdy[0]) begin
        valid_q[0] <= IN_VALID;
      end
      if (rdy[0] && IN_VALID) begin
        data_q[0] <= d_ld;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          valid_q[k] <= valid_q[k-1];
        end
        if (rdy[k] && valid_q[k-1]) begin
          data_q[k] <= ld_x ? {WIDTH{1'bx}} : data_q[k-1];
        end
      end
    end
  end

`ifdef SCS8HD_PG_CHECK_EN
  logic pg_bad;
  logic pg_fault;

  assign pg_bad = (vpwr !== 1'b1) || (vgnd !== 1'b0);

  // fault is sticky until a reset is taken with good power
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pg_fault <= pg_bad;
    end else if (pg_bad) begin
      pg_fault <= 1'b1;
    end
  end

  assign ld_x      = pg_bad;
  assign d_ld      = pg_bad ? {WIDTH{1'bx}} : d_in;
  assign Y         = (pg_bad || pg_fault) ? {WIDTH{1'bx}}
                                          : data_q[STAGES-1];
  assign OUT_VALID = (pg_bad || pg_fault) ? 1'bx
                                          : valid_q[STAGES-1];
`else
  assign ld_x      = 1'b0;
  assign d_ld      = d_in;
  assign Y         = data_q[STAGES-1];
  assign OUT_VALID = valid_q[STAGES-1];
`endif

endmodule

// File: tb/tb_scs8hd_a2111oi_pipe.sv
// Scoreboard bench: MODE=0 and MODE=1 instances share stimulus,
// a negedge monitor pops expected results on each output handshake.
module tb_scs8hd_a2111oi_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [3:0] b1, c1, d1;
  logic       in_ready0, in_ready1;
  logic       out_valid0, out_valid1;
  logic [3:0] y0, y1;
  logic [1:0] occ0, occ1;
`ifdef SCS8HD_PG_CHECK_EN
  logic       vpwr = 1'b1;
  logic       vgnd = 1'b0;
`endif

  always #5 clk = ~clk;

  scs8hd_a2111oi_pipe #(.WIDTH(4), .N_A(2), .STAGES(2), .MODE(0)) dut0 (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_READY(in_ready0),
    .A(a), .B1(b1), .C1(c1), .D1(d1),
    .OUT_VALID(out_valid0), .OUT_READY(out_ready), .Y(y0), .OCC(occ0)
`ifdef SCS8HD_PG_CHECK_EN
    , .vpwr(vpwr), .vgnd(vgnd)
`endif
  );

  scs8hd_a2111oi_pipe #(.WIDTH(4), .N_A(2), .STAGES(2), .MODE(1)) dut1 (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_READY(in_ready1),
    .A(a), .B1(b1), .C1(c1), .D1(d1),
    .OUT_VALID(out_valid1), .OUT_READY(out_ready), .Y(y1), .OCC(occ1)
`ifdef SCS8HD_PG_CHECK_EN
    , .vpwr(vpwr), .vgnd(vgnd)
`endif
  );

  localparam logic [7:0] TA [7] = '{8'h03, 8'h03, 8'hCC, 8'hFF,
                                     8'h00, 8'hAA, 8'h55};
  localparam logic [3:0] TB [7] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000,
                                     4'b0000, 4'b0000, 4'b0010};
  localparam logic [3:0] TC [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000,
                                     4'b0000, 4'b0000, 4'b0100};
  localparam logic [3:0] TD [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                     4'b1000, 4'b0000, 4'b0001};
  localparam logic [3:0] E0 [7] = '{4'b1110, 4'b1010, 4'b0100, 4'b0000,
                                     4'b0111, 4'b1111, 4'b1000};
  localparam logic [3:0] E1 [7] = '{4'b0001, 4'b0101, 4'b1011, 4'b1111,
                                     4'b1000, 4'b0000, 4'b0111};

  typedef struct packed {
    logic [3:0] y0;
    logic [3:0] y1;
    int         cyc;
    logic       lat;
  } exp_t;

  exp_t       q[$];
  logic [3:0] exp0, exp1;
  logic       lat_chk;
  logic       mon_en;
  int         cyc;
  int         checks;
  int         errors;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst || !mon_en) begin
      q.delete();
    end else begin
      if (out_valid0 && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {28'd0, y0}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("y_mode0", {28'd0, y0}, {28'd0, e.y0});
          chk("y_mode1", {28'd0, y1}, {28'd0, e.y1});
          chk("ovalid_mode1", {31'd0, out_valid1}, 32'd1);
          if (e.lat) chk("latency", cyc - e.cyc, 32'd2);
        end
      end
      if (in_valid && in_ready0)
        q.push_back('{exp0, exp1, cyc, lat_chk});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i);
    a    = TA[i];
    b1   = TB[i];
    c1   = TC[i];
    d1   = TD[i];
    exp0 = E0[i];
    exp1 = E1[i];
  endtask

  task automatic send(input int i);
    logic ok;
    ok = 1'b0;
    set_vec(i);
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready0;
      tick();
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    mon_en    = 1'b1;
    lat_chk   = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b1        = '0;
    c1        = '0;
    d1        = '0;
    exp0      = '0;
    exp1      = '0;

    // reset state
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ovalid", {31'd0, out_valid0}, 32'd0);
    chk("rst_y0", {28'd0, y0}, 32'd0);
    chk("rst_y1", {28'd0, y1}, 32'd0);
    chk("rst_occ", {30'd0, occ0}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    tick();

    // unstalled stream, both modes, latency checked
    lat_chk = 1'b1;
    send(0);
    send(1);
    lat_chk = 1'b0;
    repeat (4) tick();

    // backpressure: two beats fill the pipe, third waits
    out_ready = 1'b0;
    send(2);
    send(3);
    set_vec(4);
    in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready0}, 32'd0);
    chk("full_occ", {30'd0, occ0}, 32'd2);
    chk("stall_y0", {28'd0, y0}, {28'd0, 4'b0100});
    tick();
    chk("stall_y0_hold", {28'd0, y0}, {28'd0, 4'b0100});
    out_ready = 1'b1;
    @(negedge clk);
    chk("popfull_in_ready", {31'd0, in_ready0}, 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("shift_occ", {30'd0, occ0}, 32'd2);
    tick();
    out_ready = 1'b1;
    repeat (4) tick();

    // reset while full and stalled
    out_ready = 1'b0;
    send(5);
    send(6);
    @(negedge clk);
    chk("pre_rst_occ", {30'd0, occ0}, 32'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_occ", {30'd0, occ0}, 32'd0);
    chk("midrst_ovalid", {31'd0, out_valid0}, 32'd0);
    tick();
    out_ready = 1'b1;
    repeat (5) tick();
    send(6);
    repeat (4) tick();

`ifdef SCS8HD_PG_CHECK_EN
    // power glitch mid-stream, recover through reset
    mon_en = 1'b0;
    set_vec(2);
    in_valid = 1'b1;
    tick();
    vpwr = 1'b0;
    tick();
    vpwr = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("pg_rst_occ", {30'd0, occ0}, 32'd0);
    tick();
    lat_chk = 1'b1;
    send(0);
    send(1);
    lat_chk = 1'b0;
    repeat (4) tick();
`endif

    chk("drain_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want done");
    $fatal(1, "timeout");
  end

endmodule
